// File: rtl/sram_fp_banked.sv
// sram_fp_banked
//   Four-port, four-bank 32-bit scratchpad (4 x 4096 words) shared by the
//   four SIMT lanes. Word address bits [1:0] pick the bank and bits [13:2]
//   pick the row. Requests that lose same-bank arbitration are parked in a
//   per-port write slot or read slot. A read is held back while any parked
//   write targets the same word, so older writes are always visible to it.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset (control state and rdN only)
//   addrN [13:0]   word address of port N
//   weN            1 = write request, 0 = read request (every cycle)
//   wdN   [31:0]   write data of port N
//   rdN   [31:0]   registered read data; holds until port N's next granted read
module sram_fp_banked (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] addr0,
    input  logic [13:0] addr1,
    input  logic [13:0] addr2,
    input  logic [13:0] addr3,
    input  logic        we0,
    input  logic        we1,
    input  logic        we2,
    input  logic        we3,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    input  logic [31:0] wd2,
    input  logic [31:0] wd3,
    output logic [31:0] rd0,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] rd3
);

    logic [13:0] addr [4];
    logic [3:0]  we;
    logic [31:0] wd   [4];

    assign addr[0] = addr0;
    assign addr[1] = addr1;
    assign addr[2] = addr2;
    assign addr[3] = addr3;
    assign we      = {we3, we2, we1, we0};
    assign wd[0]   = wd0;
    assign wd[1]   = wd1;
    assign wd[2]   = wd2;
    assign wd[3]   = wd3;

    // Parked request slots and read data registers
    logic [3:0]  wv_q, wv_d;
    logic [13:0] wa_q [4];
    logic [13:0] wa_d [4];
    logic [31:0] wdat_q [4];
    logic [31:0] wdat_d [4];
    logic [3:0]  rv_q, rv_d;
    logic [13:0] ra_q [4];
    logic [13:0] ra_d [4];
    logic [31:0] rd_q [4];
    logic [31:0] rd_d [4];

    // Effective requests: a parked slot takes priority over the live input
    logic [3:0]  ew_v, er_v, rd_ok, wgnt, rgnt;
    logic [13:0] ew_a [4];
    logic [31:0] ew_d [4];
    logic [13:0] er_a [4];

    // Per-bank port signals
    logic [3:0]  bank_we;
    logic [11:0] bank_wrow  [4];
    logic [31:0] bank_wdata [4];
    logic [11:0] bank_rrow  [4];
    logic [31:0] bank_rdata [4];

    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            ew_v[n] = wv_q[n] | we[n];
            ew_a[n] = wv_q[n] ? wa_q[n]   : addr[n];
            ew_d[n] = wv_q[n] ? wdat_q[n] : wd[n];
            er_v[n] = rv_q[n] | ~we[n];
            er_a[n] = rv_q[n] ? ra_q[n]   : addr[n];
        end
    end

    // Only parked writes gate a read; a live write to the same word in the
    // same cycle lands after the read-first access and is not a hazard.
    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            rd_ok[n] = er_v[n];
            for (int unsigned m = 0; m < 4; m++) begin
                if (wv_q[m] && (wa_q[m] == er_a[n])) begin
                    rd_ok[n] = 1'b0;
                end
            end
        end
    end

    // Fixed priority per bank: lowest port index wins
    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            wgnt[n] = ew_v[n];
            rgnt[n] = rd_ok[n];
            for (int unsigned m = 0; m < n; m++) begin
                if (ew_v[m] && (ew_a[m][1:0] == ew_a[n][1:0])) begin
                    wgnt[n] = 1'b0;
                end
                if (rd_ok[m] && (er_a[m][1:0] == er_a[n][1:0])) begin
                    rgnt[n] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < 4; b++) begin
            bank_we[b]    = 1'b0;
            bank_wrow[b]  = '0;
            bank_wdata[b] = '0;
            bank_rrow[b]  = '0;
        end
        for (int unsigned n = 0; n < 4; n++) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wgnt[n] && (ew_a[n][1:0] == 2'(b))) begin
                    bank_we[b]    = 1'b1;
                    bank_wrow[b]  = ew_a[n][13:2];
                    bank_wdata[b] = ew_d[n];
                end
                if (rgnt[n] && (er_a[n][1:0] == 2'(b))) begin
                    bank_rrow[b] = er_a[n][13:2];
                end
            end
        end
    end

    // Storage is never reset; the combinational read gives pre-edge data
    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [31:0] mem [4096];

        always_ff @(posedge clk) begin
            if (bank_we[b]) begin
                mem[bank_wrow[b]] <= bank_wdata[b];
            end
        end

        assign bank_rdata[b] = mem[bank_rrow[b]];
    end

    // A request that is not granted stays in (or enters) its slot
    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            wv_d[n]   = ew_v[n] & ~wgnt[n];
            wa_d[n]   = ew_a[n];
            wdat_d[n] = ew_d[n];
            rv_d[n]   = er_v[n] & ~rgnt[n];
            ra_d[n]   = er_a[n];
            rd_d[n]   = rgnt[n] ? bank_rdata[er_a[n][1:0]] : rd_q[n];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wv_q <= '0;
            rv_q <= '0;
            for (int unsigned n = 0; n < 4; n++) begin
                wa_q[n]   <= '0;
                wdat_q[n] <= '0;
                ra_q[n]   <= '0;
                rd_q[n]   <= '0;
            end
        end else begin
            wv_q <= wv_d;
            rv_q <= rv_d;
            for (int unsigned n = 0; n < 4; n++) begin
                wa_q[n]   <= wa_d[n];
                wdat_q[n] <= wdat_d[n];
                ra_q[n]   <= ra_d[n];
                rd_q[n]   <= rd_d[n];
            end
        end
    end

    assign rd0 = rd_q[0];
    assign rd1 = rd_q[1];
    assign rd2 = rd_q[2];
    assign rd3 = rd_q[3];

endmodule

// File: tb/tb_sram_fp_banked.sv
// tb_sram_fp_banked
//   Directed test of sram_fp_banked with hand-computed expected values:
//   distinct banks, full bank conflict ordering, read-first same word,
//   same-word write collision, hazard gating and reset behaviour.
module tb_sram_fp_banked;

    logic        clk;
    logic        reset;
    logic [13:0] addr0, addr1, addr2, addr3;
    logic        we0, we1, we2, we3;
    logic [31:0] wd0, wd1, wd2, wd3;
    logic [31:0] rd0, rd1, rd2, rd3;

    int unsigned n_checks;
    int unsigned n_fail;

    sram_fp_banked dut (
        .clk   (clk),
        .reset (reset),
        .addr0 (addr0),
        .addr1 (addr1),
        .addr2 (addr2),
        .addr3 (addr3),
        .we0   (we0),
        .we1   (we1),
        .we2   (we2),
        .we3   (we3),
        .wd0   (wd0),
        .wd1   (wd1),
        .wd2   (wd2),
        .wd3   (wd3),
        .rd0   (rd0),
        .rd1   (rd1),
        .rd2   (rd2),
        .rd3   (rd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic drive(input int unsigned p, input logic w, input logic [13:0] a, input logic [31:0] d);
        case (p)
            0: begin we0 = w; addr0 = a; wd0 = d; end
            1: begin we1 = w; addr1 = a; wd1 = d; end
            2: begin we2 = w; addr2 = a; wd2 = d; end
            default: begin we3 = w; addr3 = a; wd3 = d; end
        endcase
    endtask

    // Idle reads land in four different banks, with port 0 kept off bank 0
    // so parked bank-0 reads of higher ports can drain.
    task automatic set_idle();
        drive(0, 1'b0, 14'd101, '0);
        drive(1, 1'b0, 14'd102, '0);
        drive(2, 1'b0, 14'd103, '0);
        drive(3, 1'b0, 14'd100, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ticks(input int unsigned k);
        set_idle();
        for (int unsigned i = 0; i < k; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        set_idle();
        #2 reset = 1'b0;
        #1;
        check("reset rd0", rd0, 32'd0);
        check("reset rd1", rd1, 32'd0);
        check("reset rd2", rd2, 32'd0);
        check("reset rd3", rd3, 32'd0);
        tick();
        tick();
        reset = 1'b1;

        // Distinct banks
        drive(0, 1'b1, 14'd0, 32'd123);
        drive(1, 1'b1, 14'd5, 32'd456);
        drive(2, 1'b1, 14'd3, 32'd789);
        drive(3, 1'b1, 14'd2, 32'd5555);
        tick();
        drive(0, 1'b0, 14'd5, '0);
        drive(1, 1'b0, 14'd2, '0);
        drive(2, 1'b0, 14'd3, '0);
        drive(3, 1'b0, 14'd0, '0);
        tick();
        check("distinct rd0", rd0, 32'd456);
        check("distinct rd1", rd1, 32'd5555);
        check("distinct rd2", rd2, 32'd789);
        check("distinct rd3", rd3, 32'd123);
        idle_ticks(2);

        // Full bank conflict ordering
        drive(0, 1'b1, 14'd12, 32'd123);
        drive(1, 1'b1, 14'd8,  32'd456);
        drive(2, 1'b1, 14'd4,  32'd789);
        drive(3, 1'b1, 14'd0,  32'd5555);
        tick();                                   // edge 1
        drive(0, 1'b0, 14'd0,  '0);
        drive(1, 1'b0, 14'd4,  '0);
        drive(2, 1'b0, 14'd8,  '0);
        drive(3, 1'b0, 14'd12, '0);
        tick();                                   // edge 2
        check("conflict rd3 e2", rd3, 32'd123);
        tick();                                   // edge 3
        tick();                                   // edge 4
        check("conflict rd2 e4", rd2, 32'd456);
        check("conflict rd3 e4", rd3, 32'd123);
        tick();                                   // edge 5
        tick();                                   // edge 6
        check("conflict rd1 e6", rd1, 32'd789);
        tick();                                   // edge 7
        tick();                                   // edge 8
        check("conflict rd0 e8", rd0, 32'd5555);
        check("conflict rd1 e8", rd1, 32'd789);
        check("conflict rd2 e8", rd2, 32'd456);
        check("conflict rd3 e8", rd3, 32'd123);
        idle_ticks(6);

        // Same-cycle read and write of one word on different ports
        drive(0, 1'b1, 14'd40, 32'd111);
        tick();
        drive(0, 1'b1, 14'd40, 32'd222);
        drive(1, 1'b0, 14'd40, '0);
        tick();
        check("rfirst old", rd1, 32'd111);
        drive(0, 1'b0, 14'd101, '0);
        tick();
        check("rfirst new", rd1, 32'd222);
        idle_ticks(4);

        // Same-word write collision: higher port survives
        drive(1, 1'b1, 14'd20, 32'd7);
        drive(3, 1'b1, 14'd20, 32'd9);
        tick();
        set_idle();
        drive(0, 1'b0, 14'd20, '0);
        tick();
        tick();
        check("collision word20", rd0, 32'd9);
        idle_ticks(4);

        // Hazard gating: parked write to word 4 must land before port 1 reads it
        drive(0, 1'b1, 14'd0, 32'hAAAA);
        drive(2, 1'b1, 14'd4, 32'hBBBB);
        drive(1, 1'b0, 14'd5, '0);
        drive(3, 1'b0, 14'd3, '0);
        tick();                                   // edge A
        check("hazard pre rd1", rd1, 32'd456);
        drive(0, 1'b0, 14'd1, '0);
        drive(1, 1'b0, 14'd4, '0);
        drive(2, 1'b0, 14'd2, '0);
        drive(3, 1'b0, 14'd3, '0);
        tick();                                   // edge B
        check("hazard hold rd1", rd1, 32'd456);
        tick();                                   // edge C
        check("hazard new rd1", rd1, 32'hBBBB);
        idle_ticks(4);

        // Reset with writes buffered
        drive(0, 1'b1, 14'd0,  32'h11);
        drive(1, 1'b1, 14'd4,  32'h44);
        drive(2, 1'b1, 14'd8,  32'h88);
        drive(3, 1'b1, 14'd12, 32'hCC);
        tick();
        reset = 1'b0;
        #1;
        check("midreset rd0", rd0, 32'd0);
        check("midreset rd1", rd1, 32'd0);
        check("midreset rd2", rd2, 32'd0);
        check("midreset rd3", rd3, 32'd0);
        set_idle();
        tick();
        tick();
        reset = 1'b1;
        drive(0, 1'b0, 14'd8,   '0);
        drive(1, 1'b1, 14'd201, 32'hCAFE);
        drive(2, 1'b0, 14'd2,   '0);
        drive(3, 1'b0, 14'd3,   '0);
        tick();
        check("post reset word8", rd0, 32'd456);
        check("post reset word2", rd2, 32'd5555);
        check("post reset word3", rd3, 32'd789);
        set_idle();
        drive(0, 1'b0, 14'd0,   '0);
        drive(2, 1'b0, 14'd201, '0);
        tick();
        check("post reset word0", rd0, 32'h11);
        check("post reset word201", rd2, 32'hCAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
